// File: rtl/cpsr_unit_pkg.sv
// Shared flag indices, condition encodings and ALU opcodes for the execute pipeline.
package cpsr_unit_pkg;

  localparam int FLAGSW = 4;
  localparam int Z_I    = 0;
  localparam int C_I    = 1;
  localparam int N_I    = 2;
  localparam int V_I    = 3;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_EOR = 4'b0001,
    ALU_SUB = 4'b0010,
    ALU_RSB = 4'b0011,
    ALU_ADD = 4'b0100,
    ALU_ADC = 4'b0101,
    ALU_SBC = 4'b0110,
    ALU_RSC = 4'b0111,
    ALU_TST = 4'b1000,
    ALU_TEQ = 4'b1001,
    ALU_CMP = 4'b1010,
    ALU_CMN = 4'b1011,
    ALU_ORR = 4'b1100,
    ALU_MOV = 4'b1101,
    ALU_BIC = 4'b1110,
    ALU_MVN = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/cpsr_unit_if.sv
// Execute/decode-side flag bus between the pipeline and the CPSR unit.
interface cpsr_unit_if #(parameter int FLAGSW = 4);

  logic              ex_valid;
  logic              ex_setflags;
  logic [FLAGSW-1:0] ex_flags;
  logic [FLAGSW-1:0] ex_wmask;
  logic              flush;
  logic [3:0]        id_cond;
  logic              id_pass;
  logic              carry_fwd;
  logic [FLAGSW-1:0] cpsr;
  logic              pend_valid;

  modport master (
    output ex_valid, ex_setflags, ex_flags, ex_wmask, flush, id_cond,
    input  id_pass, carry_fwd, cpsr, pend_valid
  );

  modport slave (
    input  ex_valid, ex_setflags, ex_flags, ex_wmask, flush, id_cond,
    output id_pass, carry_fwd, cpsr, pend_valid
  );

endinterface

// File: rtl/cpsr_unit_cond_eval.sv
// Combinational ARM condition-code evaluator; shared with the branch unit.
module cond_eval
  import cpsr_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic z, c, n, v;

  assign z = flags[Z_I];
  assign c = flags[C_I];
  assign n = flags[N_I];
  assign v = flags[V_I];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpsr_unit.sv
// Condition flag register with a one-deep pending write stage and a
// forwarding path so decode sees flags from in-flight instructions.
module cpsr_unit
  import cpsr_unit_pkg::*;
#(
  parameter int FLAGSW = cpsr_unit_pkg::FLAGSW
) (
  input logic         clk,
  input logic         nrst,
  cpsr_unit_if.slave  bus
);

  logic [FLAGSW-1:0] cpsr_q, cpsr_d;
  logic [FLAGSW-1:0] pend_flags_q, pend_flags_d;
  logic [FLAGSW-1:0] pend_mask_q, pend_mask_d;
  logic              pend_valid_q, pend_valid_d;

  logic              req;
  logic              take;
  logic [FLAGSW-1:0] pend_merged;
  logic [FLAGSW-1:0] base;
  logic [FLAGSW-1:0] eff;

  assign req  = bus.ex_valid & bus.ex_setflags & (|bus.ex_wmask);
  assign take = req & ~bus.flush;

  assign pend_merged = (pend_mask_q & pend_flags_q) | (~pend_mask_q & cpsr_q);

  // Flush does not hide the pending entry from decode in the flush cycle itself.
  assign base = pend_valid_q ? pend_merged : cpsr_q;
  assign eff  = take ? ((bus.ex_wmask & bus.ex_flags) | (~bus.ex_wmask & base)) : base;

  always_comb begin
    cpsr_d       = cpsr_q;
    pend_flags_d = pend_flags_q;
    pend_mask_d  = pend_mask_q;
    pend_valid_d = 1'b0;
    if (!bus.flush) begin
      if (pend_valid_q) cpsr_d = pend_merged;
      if (req) begin
        pend_valid_d = 1'b1;
        pend_flags_d = bus.ex_flags;
        pend_mask_d  = bus.ex_wmask;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cpsr_q       <= '0;
      pend_flags_q <= '0;
      pend_mask_q  <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      cpsr_q       <= cpsr_d;
      pend_flags_q <= pend_flags_d;
      pend_mask_q  <= pend_mask_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  cond_eval u_cond_eval (
    .cond  (bus.id_cond),
    .flags (eff[3:0]),
    .pass  (bus.id_pass)
  );

  assign bus.carry_fwd  = eff[C_I];
  assign bus.cpsr       = cpsr_q;
  assign bus.pend_valid = pend_valid_q;

endmodule

// File: tb/tb_cpsr_unit.sv
// Directed bench for cpsr_unit: condition table, hazard/merge/flush sequences, reset.
module tb_cpsr_unit;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  cpsr_unit_if #(.FLAGSW(4)) bus ();

  cpsr_unit #(.FLAGSW(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       pass;
  } vec_t;

  vec_t vecs[18];

  function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
    logic zf, cf, nf, vf;
    logic r;
    zf = f[0]; cf = f[1]; nf = f[2]; vf = f[3];
    r = 1'b0;
    if      (c == 4'd0)  r = zf;
    else if (c == 4'd1)  r = !zf;
    else if (c == 4'd2)  r = cf;
    else if (c == 4'd3)  r = !cf;
    else if (c == 4'd4)  r = nf;
    else if (c == 4'd5)  r = !nf;
    else if (c == 4'd6)  r = vf;
    else if (c == 4'd7)  r = !vf;
    else if (c == 4'd8)  r = cf && !zf;
    else if (c == 4'd9)  r = !cf || zf;
    else if (c == 4'd10) r = (nf ~^ vf);
    else if (c == 4'd11) r = (nf ^ vf);
    else if (c == 4'd12) r = !zf && (nf ~^ vf);
    else if (c == 4'd13) r = zf || (nf ^ vf);
    else if (c == 4'd14) r = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] f,
                       input logic [3:0] m, input logic fl);
    bus.ex_valid    = v;
    bus.ex_setflags = s;
    bus.ex_flags    = f;
    bus.ex_wmask    = m;
    bus.flush       = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{4'd0,  4'b0001, 1'b1};
    vecs[1]  = '{4'd1,  4'b0001, 1'b0};
    vecs[2]  = '{4'd2,  4'b0010, 1'b1};
    vecs[3]  = '{4'd3,  4'b0010, 1'b0};
    vecs[4]  = '{4'd4,  4'b0100, 1'b1};
    vecs[5]  = '{4'd5,  4'b0100, 1'b0};
    vecs[6]  = '{4'd6,  4'b1000, 1'b1};
    vecs[7]  = '{4'd7,  4'b0000, 1'b1};
    vecs[8]  = '{4'd8,  4'b0010, 1'b1};
    vecs[9]  = '{4'd8,  4'b0011, 1'b0};
    vecs[10] = '{4'd9,  4'b0011, 1'b1};
    vecs[11] = '{4'd10, 4'b1100, 1'b1};
    vecs[12] = '{4'd11, 4'b1000, 1'b1};
    vecs[13] = '{4'd12, 4'b0000, 1'b1};
    vecs[14] = '{4'd12, 4'b0001, 1'b0};
    vecs[15] = '{4'd13, 4'b0100, 1'b1};
    vecs[16] = '{4'd14, 4'b0000, 1'b1};
    vecs[17] = '{4'd15, 4'b1111, 1'b0};

    nrst = 1'b0;
    idle();
    bus.id_cond = 4'd14;
    #12;
    chk("rst_cpsr", bus.cpsr, 4'b0000);
    chk("rst_pend", {3'b0, bus.pend_valid}, 4'd0);
    chk("rst_al", {3'b0, bus.id_pass}, 4'd1);
    chk("rst_carry", {3'b0, bus.carry_fwd}, 4'd0);
    bus.id_cond = 4'd0; #1;
    chk("rst_eq", {3'b0, bus.id_pass}, 4'd0);
    bus.id_cond = 4'd1; #1;
    chk("rst_ne", {3'b0, bus.id_pass}, 4'd1);
    tick();
    nrst = 1'b1;
    tick();

    // Setflags without valid, and a zero write mask, must not create a write.
    drive(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0);
    tick();
    chk("novalid_pend", {3'b0, bus.pend_valid}, 4'd0);
    drive(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0);
    tick();
    chk("nomask_pend", {3'b0, bus.pend_valid}, 4'd0);
    chk("nomask_cpsr", bus.cpsr, 4'b0000);

    // Back-to-back hazard: Z forwarded to decode in the execute cycle.
    bus.id_cond = 4'd0;
    drive(1'b1, 1'b1, 4'b0001, 4'b1111, 1'b0);
    #1;
    chk("haz_eq_same", {3'b0, bus.id_pass}, 4'd1);
    tick();
    idle();
    #1;
    chk("haz_pend", {3'b0, bus.pend_valid}, 4'd1);
    chk("haz_cpsr_e1", bus.cpsr, 4'b0000);
    chk("haz_eq_e1", {3'b0, bus.id_pass}, 4'd1);
    tick();
    chk("haz_cpsr_e2", bus.cpsr, 4'b0001);
    chk("haz_pend_e2", {3'b0, bus.pend_valid}, 4'd0);

    // Partial mask preserves V and C.
    drive(1'b1, 1'b1, 4'b1010, 4'b1111, 1'b0);
    tick(); idle(); tick();
    chk("pm_setup", bus.cpsr, 4'b1010);
    drive(1'b1, 1'b1, 4'b0101, 4'b0101, 1'b0);
    bus.id_cond = 4'd2;
    #1;
    chk("pm_carry_fwd", {3'b0, bus.carry_fwd}, 4'd1);
    tick(); idle(); tick();
    chk("pm_cpsr", bus.cpsr, 4'b1111);

    // Flush squashes the pending write.
    bus.id_cond = 4'd0;
    drive(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1);
    tick();
    idle();
    #1;
    chk("fl_cpsr", bus.cpsr, 4'b1111);
    chk("fl_pend", {3'b0, bus.pend_valid}, 4'd0);
    chk("fl_eq", {3'b0, bus.id_pass}, 4'd1);
    chk("fl_carry", {3'b0, bus.carry_fwd}, 4'd1);
    tick();
    chk("fl_cpsr_late", bus.cpsr, 4'b1111);

    // A clears Z,C; B sets Z: eff = 1101, cpsr 1100 then 1101.
    drive(1'b1, 1'b1, 4'b0000, 4'b0011, 1'b0);
    tick();
    drive(1'b1, 1'b1, 4'b0011, 4'b0001, 1'b0);
    #1;
    chk("ab_carry", {3'b0, bus.carry_fwd}, 4'd0);
    chk("ab_eq", {3'b0, bus.id_pass}, 4'd1);
    chk("ab_cpsr_e1", bus.cpsr, 4'b1111);
    tick();
    idle();
    #1;
    chk("ab_cpsr_e2", bus.cpsr, 4'b1100);
    chk("ab_eq_e2", {3'b0, bus.id_pass}, 4'd1);
    tick();
    chk("ab_cpsr_e3", bus.cpsr, 4'b1101);

    // Async reset with a write pending.
    drive(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);
    tick();
    idle();
    bus.id_cond = 4'd1;
    #1;
    chk("ar_pend_before", {3'b0, bus.pend_valid}, 4'd1);
    nrst = 1'b0;
    #1;
    chk("ar_cpsr", bus.cpsr, 4'b0000);
    chk("ar_pend", {3'b0, bus.pend_valid}, 4'd0);
    chk("ar_ne", {3'b0, bus.id_pass}, 4'd1);
    #1;
    nrst = 1'b1;
    drive(1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0);
    tick(); idle(); tick();
    chk("ar_after", bus.cpsr, 4'b0010);

    // Hand-computed condition table via the forwarding path.
    for (int i = 0; i < 18; i++) begin
      bus.id_cond = vecs[i].cond;
      drive(1'b1, 1'b1, vecs[i].flags, 4'b1111, 1'b0);
      #1;
      chk($sformatf("tbl%0d", i), {3'b0, bus.id_pass}, {3'b0, vecs[i].pass});
    end

    // Full sweep of conditions and flag values.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        bus.id_cond = 4'(c);
        drive(1'b1, 1'b1, 4'(f), 4'b1111, 1'b0);
        #1;
        chk($sformatf("sw_c%0d_f%0d", c, f), {3'b0, bus.id_pass},
            {3'b0, model_pass(4'(c), 4'(f))});
        chk($sformatf("swc_f%0d", f), {3'b0, bus.carry_fwd}, {3'b0, f[1]});
      end
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpsr_unit.md
CPSR_UNIT -- requirements
Module: cpsr_unit

Interface
REQ-001 Parameter FLAGSW, default 4, flag vector width; bit order is Z=0, C=1, N=2, V=3, the same order as the ALU flag output.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 nrst  input  1  reset, asynchronous assert, active-low.
REQ-004 ex_valid  input  1  an execute-stage instruction is present this cycle.
REQ-005 ex_setflags  input  1  the execute instruction has its S bit set or is TST/TEQ/CMP/CMN, and its condition passed.
REQ-006 ex_flags  input  FLAGSW  flags from the ALU for the execute instruction.
REQ-007 ex_wmask  input  FLAGSW  per-flag write enable; logical ops clear the V bit, and PASS clears the C bit when the shifter carry is unused.
REQ-008 flush  input  1  squashes the pending flag write.
REQ-009 id_cond  input  4  condition field of the decode-stage instruction.
REQ-010 id_pass  output  1  the decode-stage condition evaluates true.
REQ-011 carry_fwd  output  1  forwarded C flag for the shifter (RRX, carry-in).
REQ-012 cpsr  output  FLAGSW  committed flag register.
REQ-013 pend_valid  output  1  a flag write is pending commit.

Function
REQ-014 The write request is req = ex_valid & ex_setflags & (ex_wmask != 0).
REQ-015 When req is high, the block SHALL capture pend_flags <= ex_flags and pend_mask <= ex_wmask on the clock edge, and set pend_valid.
REQ-016 When pend_valid is high, the block SHALL update cpsr on the next clock edge: each bit i becomes pend_mask[i] ? pend_flags[i] : cpsr[i].
- Architectural flag latency is 2 edges after the execute cycle.
REQ-017 pend_valid SHALL clear on any edge without a new req; a new req on the same edge SHALL overwrite the pending entry, and the old entry still commits that edge.
REQ-018 When flush is high, the block SHALL not commit the pending entry, SHALL clear pend_valid, and SHALL ignore req in that cycle.
REQ-019 Effective flags eff SHALL be computed combinationally with this priority:
- req and no flush: mask-merge of ex_flags over (pending merged over cpsr);
- else pend_valid: pending merged over cpsr;
- else cpsr.
REQ-020 carry_fwd SHALL equal eff[C].
REQ-021 id_pass SHALL be evaluated from eff:
- EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V;
- HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V);
- 1110 always true; 1111 false.
REQ-022 id_pass and carry_fwd SHALL be purely combinational, with zero cycles of latency from inputs.
REQ-023 ex_setflags with ex_valid low SHALL have no effect.

Reset
REQ-024 While nrst is low, the block SHALL hold cpsr=0 and pend_valid=0 (pending flags/mask 0); id_pass then reflects flags 0 (EQ false, NE true, AL true).
REQ-025 Reset asserted mid-pending SHALL discard the pending write; the first edge after deassert performs normal updates.

Structure
REQ-026 Flag indices Z_i/C_i/N_i/V_i, FLAGSW and the 4-bit condition encodings SHALL live in the shared defines file alongside the ALU opcodes.
REQ-027 Condition evaluation SHALL be a combinational sub-module, cond_eval (inputs cond and flags; output pass), reusable by the branch unit.

Verification
REQ-028 Reset, then AL/EQ/NE with idle inputs -> cpsr=0000, id_pass 1/0/1, carry_fwd 0.
REQ-029 Back-to-back hazard: req with ex_flags=0001 (Z), mask 1111, while id_cond=EQ -> id_pass=1 the same cycle; cpsr=0001 after 2 edges.
REQ-030 Partial mask: cpsr=1010 (V,C), then req with ex_flags=0101 and mask 0101 -> cpsr becomes 1111; V and C preserved.
REQ-031 Flush: req at cycle t, flush at t+1 -> cpsr unchanged, pend_valid=0 at t+2, id_pass tracks the old cpsr.
REQ-032 Consecutive reqs A then B -> eff reflects B merged over A; cpsr=A after edge 2, merged B after edge 3.
REQ-033 Sweep all 16 conditions × 16 flag values against the REQ-021 table; async reset asserted mid-pending -> outputs at 0 immediately.
